// File: rtl/muldiv_iter_unit_if.sv
// Handshake/operand bundle for muldiv_iter_unit; the master is the EX-stage
// issuer, the slave is the iterative unit.
interface muldiv_iter_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cpu_stall;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (output start, op, a, b, cpu_stall, cancel,
                  input  busy, done, hi, lo, div_by_zero);
  modport slave  (input  start, op, a, b, cpu_stall, cancel,
                  output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/muldiv_iter_unit.sv
// Iterative MULTU/MULT/DIVU/DIV unit: one shift/add-subtract datapath, UNROLL bits per RUN cycle.
// Optional MULDIV_EARLY_OUT_EN skips RUN for trivially-zero products and |a| < |b| divides.
module muldiv_iter_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input logic               clk,
  input logic               reset_n,
  muldiv_iter_unit_if.slave bus
);
  localparam int K  = WIDTH / UNROLL;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, opd_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_step, prod;
  logic [CW-1:0]      cnt_q;
  logic               sign_q, sign_r, dz_q;
  logic [WIDTH-1:0]   am, bm, rem, quo, res_hi, res_lo;
  logic [WIDTH:0]     sum;
  logic               early, is_div, go, div_zero;

  assign is_div   = op_q[1];
  assign go       = !bus.cancel && !bus.cpu_stall;
  assign am       = (op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
  assign bm       = (op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;
  assign div_zero = is_div && (b_q == '0);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = is_div ? ((bm != '0) && (am < bm)) : ((am == '0) || (bm == '0));
`else
  assign early = 1'b0;
`endif

  // acc holds {partial product, multiplier} for multiply, {remainder, quotient} for divide
  always_comb begin
    acc_step = acc_q;
    sum      = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        sum = acc_step[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
        if (!sum[WIDTH]) acc_step = {sum[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b1};
        else             acc_step = {acc_step[2*WIDTH-2:0], 1'b0};
      end else begin
        sum      = {1'b0, acc_step[2*WIDTH-1:WIDTH]} + (acc_step[0] ? {1'b0, opd_q} : '0);
        acc_step = {sum, acc_step[WIDTH-1:1]};
      end
    end
  end

  assign prod = sign_q ? -acc_q : acc_q;
  assign rem  = acc_q[2*WIDTH-1:WIDTH];
  assign quo  = acc_q[WIDTH-1:0];

  always_comb begin
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = sign_r ? -rem : rem;
        res_lo = sign_q ? -quo : quo;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.cancel) state_d = IDLE;
    else if (!bus.cpu_stall) begin
      case (state_q)
        IDLE:    if (bus.start) state_d = PREP;
        PREP:    state_d = early ? FIX : RUN;
        RUN:     if (cnt_q == CW'(K-1)) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = bus.start ? PREP : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      opd_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else if (go) begin
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          op_q <= bus.op;
          a_q  <= bus.a;
          b_q  <= bus.b;
          dz_q <= 1'b0;
        end
        PREP: begin
          sign_q <= op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_r <= op_q[0] & a_q[WIDTH-1];
          opd_q  <= is_div ? bm : am;
          cnt_q  <= '0;
          if (early) acc_q <= is_div ? {am, {WIDTH{1'b0}}} : '0;
          else       acc_q <= {{WIDTH{1'b0}}, (is_div ? am : bm)};
        end
        RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
          dz_q <= div_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit: a 32-bit/UNROLL=1 instance and a 16-bit/UNROLL=4 instance.
module tb_muldiv_iter_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  muldiv_iter_unit_if #(.WIDTH(32)) bus();
  muldiv_iter_unit_if #(.WIDTH(16)) bus16();

  muldiv_iter_unit #(.WIDTH(32), .UNROLL(1)) dut   (.clk(clk), .reset_n(reset_n), .bus(bus));
  muldiv_iter_unit #(.WIDTH(16), .UNROLL(4)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

  int   n_chk  = 0;
  int   n_fail = 0;
  int   lat;
  logic busy_ok;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // lat = number of edges after the accept edge until done is seen
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int stall_from);
    bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_ok = bus.busy;
    while (!bus.done && lat < 200) begin
      bus.cpu_stall = (lat >= stall_from) && (lat < stall_from + 3);
      @(posedge clk); #1;
      lat++;
      busy_ok &= bus.busy;
    end
    bus.cpu_stall = 1'b0;
  endtask

  task automatic do_op16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    bus16.op = o; bus16.a = x; bus16.b = y; bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    lat = 0;
    while (!bus16.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cpu_stall = 1'b0; bus.cancel = 1'b0;
    bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0;
    bus16.cpu_stall = 1'b0; bus16.cancel = 1'b0;
    #2 reset_n = 1'b0;
    #20;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_dz",   {63'd0, bus.div_by_zero}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // MULTU max*max, latency, busy coverage, single done pulse
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1000);
    chk("multu_lat",  lat, 34);
    chk("multu_busy", {63'd0, busy_ok}, 64'd1);
    chk("multu_res",  {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    chk("multu_pulse", {62'd0, bus.done, bus.busy}, 64'd0);

    // MULT then back-to-back DIV issued in the DONE cycle
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1000);
    chk("mult_lat", lat, 34);
    chk("mult_res", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1000);
    chk("div_b2b_lat", lat, 34);
    chk("div_b2b_res", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV overflow, then divide by zero
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1000);
    chk("div_ovf_res", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    chk("div_ovf_dz",  {63'd0, bus.div_by_zero}, 64'd0);
    do_op(2'b10, 32'd5, 32'd0, 1000);
    chk("dz_lat", lat, 34);
    chk("dz_res", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
    chk("dz_flag", {63'd0, bus.div_by_zero}, 64'd1);
    @(posedge clk); #1;

    // stalled MULTU; flag must have cleared at accept
    do_op(2'b00, 32'd6, 32'd7, 5);
    chk("stall_lat", lat, 37);
    chk("stall_res", {bus.hi, bus.lo}, 64'd42);
    chk("stall_dz",  {63'd0, bus.div_by_zero}, 64'd0);
    @(posedge clk); #1;

    // cancel mid-RUN
    bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk("cancel_busy", {63'd0, bus.busy}, 64'd0);
    busy_ok = 1'b0;
    repeat (40) begin @(posedge clk); #1; busy_ok |= bus.done; end
    chk("cancel_nodone", {63'd0, busy_ok}, 64'd0);
    chk("cancel_hold", {bus.hi, bus.lo}, 64'd42);

    // asynchronous reset mid-RUN
    bus.op = 2'b00; bus.a = 32'h1234; bus.b = 32'h5678; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", {bus.hi, bus.lo}, 64'd0);
    chk("arst_ctl", {62'd0, bus.busy, bus.done}, 64'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    do_op(2'b00, 32'd2, 32'd3, 1000);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_res", {bus.hi, bus.lo}, 64'd6);

    // 16-bit, 4 bits per cycle
    do_op16(2'b10, 16'd100, 16'd7);
    chk("w16_divu_lat", lat, 6);
    chk("w16_divu_res", {32'd0, bus16.hi, bus16.lo}, {32'd0, 16'd2, 16'd14});
    do_op16(2'b01, 16'hFFFD, 16'd5);
    chk("w16_mult_lat", lat, 6);
    chk("w16_mult_res", {32'd0, bus16.hi, bus16.lo}, {32'd0, 16'hFFFF, 16'hFFF1});
    do_op16(2'b10, 16'd3, 16'd7);
`ifdef MULDIV_EARLY_OUT_EN
    chk("w16_small_lat", lat, 2);
`else
    chk("w16_small_lat", lat, 6);
`endif
    chk("w16_small_res", {32'd0, bus16.hi, bus16.lo}, {32'd0, 16'd3, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
